inst_fetch_unit: RTL

- Fetch stage of the multi-cycle CPU.
- Owns the program counter and drives the instruction memory address and read enable.
- Captures the returned instruction word into the instruction register (IR).
- Computes the next PC on the controller's PCWre strobe and detects the halt opcode and misaligned fetch targets.
- Sits directly upstream of the instruction memory and feeds IR to the control unit and register file.

---
 rtl/inst_fetch_unit.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/inst_fetch_unit.sv
// Fetch stage of the multi-cycle CPU. It owns the PC, runs the instruction
// memory read handshake and holds the fetched word in IR for the controller.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MEM_LAT  = 1,
    parameter logic [5:0]  HALT_OP  = 6'b111111
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        PCWre,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] ExtImm,
    input  logic [31:0] RegRs,
    input  logic [31:0] IDataIn,
    output logic [31:0] IAddr,
    output logic        InsMemRW,
    output logic [31:0] IR,
    output logic [31:0] PC,
    output logic [31:0] PC4,
    output logic        ir_valid,
    output logic        halted,
    output logic        addr_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic        ir_valid_q, ir_valid_d;
    logic        halted_q, halted_d;
    logic        addr_err_q, addr_err_d;
    logic [3:0]  lat_cnt_q, lat_cnt_d;

    logic [31:0] pc_plus4;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] target;
    logic        target_misaligned;
    logic        halt_opcode;

    always_comb begin
        pc_plus4      = pc_q + 32'd4;
        branch_target = pc_plus4 + (ExtImm << 2);
        jump_target   = {pc_plus4[31:28], ir_q[25:0], 2'b00};
        case (PCSrc)
            2'b00:   target = pc_plus4;
            2'b01:   target = branch_target;
            2'b10:   target = RegRs;
            default: target = jump_target;
        endcase
        target_misaligned = (target[1:0] != 2'b00);
        halt_opcode       = (ir_q[31:26] == HALT_OP);
    end

    // A halt opcode in IR takes priority over any PCWre seen in HOLD.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        halted_d   = halted_q;
        addr_err_d = addr_err_q;
        lat_cnt_d  = lat_cnt_q;

        case (state_q)
            IDLE: begin
                lat_cnt_d = 4'd0;
                state_d   = FETCH;
            end
            FETCH: begin
                if (lat_cnt_q == LAST_CNT) begin
                    ir_d       = IDataIn;
                    ir_valid_d = 1'b1;
                    lat_cnt_d  = 4'd0;
                    state_d    = HOLD;
                end else begin
                    lat_cnt_d = lat_cnt_q + 4'd1;
                end
            end
            HOLD: begin
                if (halt_opcode) begin
                    halted_d = 1'b1;
                    state_d  = HALT;
                end else if (PCWre) begin
                    ir_valid_d = 1'b0;
                    if (target_misaligned) begin
                        addr_err_d = 1'b1;
                        halted_d   = 1'b1;
                        state_d    = HALT;
                    end else begin
                        pc_d    = target;
                        state_d = FETCH;
                    end
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            ir_q       <= 32'd0;
            ir_valid_q <= 1'b0;
            halted_q   <= 1'b0;
            addr_err_q <= 1'b0;
            lat_cnt_q  <= 4'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            halted_q   <= halted_d;
            addr_err_q <= addr_err_d;
            lat_cnt_q  <= lat_cnt_d;
        end
    end

    assign IAddr    = pc_q;
    assign PC       = pc_q;
    assign PC4      = pc_plus4;
    assign InsMemRW = (state_q == FETCH);
    assign IR       = ir_q;
    assign ir_valid = ir_valid_q;
    assign halted   = halted_q;
    assign addr_err = addr_err_q;

endmodule
